clock_divider_bank: RTL and testbench

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clkdiv_pkg.sv | 28 ++
 rtl/clkdiv_channel.sv | 90 +++++++++
 rtl/clock_divider_bank.sv | 77 +++++++
 tb/tb_clock_divider_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock divider bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package clkdiv_pkg;

    // Upper bound on the number of divider channels in one bank.
    localparam int MAX_CH    = 16;

    // Internal datapath width for ratios and counters. Narrower DIV_W
    // values are zero-extended, so the unused upper bits stay constant.
    localparam int MAX_DIV_W = 32;

    typedef logic [MAX_DIV_W-1:0] div_t;

    // Complete per-channel state.
    typedef struct packed {
        div_t div;       // active divide ratio D (0 = disabled)
        div_t cnt;       // position in the period, 0..D-1
        div_t pend;      // ratio waiting for the next period boundary
        logic pend_vld;  // pend holds an accepted, not yet applied ratio
    } ch_state_t;

    // ceil(d/2): number of high cycles in one divided period.
    function automatic div_t ceil_half(input div_t d);
        return (d >> 1) + div_t'(d[0]);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending ratio, registered clk_out/tick.
// Latency: outputs are registered one cycle after the counter state they decode.
// Backpressure: o_pend_vld is high while a ratio is pending; the parent must not write then.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_sync,
    output logic             o_pend_vld,
    output logic             o_clk_out,
    output logic             o_tick
);

    localparam div_t RST_DIV = div_t'(DEFAULT_DIV);

    ch_state_t r_st;
    ch_state_t w_st_nxt;
    logic      w_run;
    logic      w_bnd;
    logic      w_tick_nxt;
    logic      w_clk_nxt;
    logic      r_tick;
    logic      r_clk_out;

    // A disabled channel sits at a permanent boundary so a new ratio
    // loads on the very next edge. A sync request also counts as a boundary.
    assign w_run = (r_st.div != '0);
    assign w_bnd = i_sync || !w_run || (r_st.cnt == r_st.div - div_t'(1));

    // Output decode works on the current counter, so the registered
    // outputs trail the counter by exactly one cycle.
    assign w_tick_nxt = w_run && (r_st.cnt == '0);
    assign w_clk_nxt  = w_run && (r_st.cnt < ceil_half(r_st.div));

    // Next-state: wrap or advance the counter, swap in the pending ratio at a
    // boundary, and capture a new write. The swap uses the registered pend_vld,
    // so a write landing in a boundary cycle waits for the following boundary.
    always_comb begin
        w_st_nxt = r_st;
        if (w_bnd) begin
            w_st_nxt.cnt = '0;
            if (r_st.pend_vld) begin
                w_st_nxt.div      = r_st.pend;
                w_st_nxt.pend_vld = 1'b0;
            end
        end else begin
            w_st_nxt.cnt = r_st.cnt + div_t'(1);
        end
        // The parent only writes while pend_vld is clear, so this never
        // collides with the swap above.
        if (i_wr) begin
            w_st_nxt.pend     = div_t'(i_div);
            w_st_nxt.pend_vld = 1'b1;
        end
    end

    // Channel state register; reset discards any pending ratio.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_st.div      <= RST_DIV;
            r_st.cnt      <= '0;
            r_st.pend     <= '0;
            r_st.pend_vld <= 1'b0;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Registered outputs: no input reaches clk_out/tick combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_tick    <= w_tick_nxt;
            r_clk_out <= w_clk_nxt;
        end
    end

    assign o_pend_vld = r_st.pend_vld;
    assign o_tick     = r_tick;
    assign o_clk_out  = r_clk_out;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of N_CH independent clock dividers with a shared config write port; CLKDIV_SYNC_EN adds a sync restart input.
// Latency: clk_out/tick are registered, one cycle after the channel counter state.
// Backpressure: cfg_ready drops while the addressed channel already holds a pending ratio.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int  N_CH        = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    // Reject unsupported configurations at elaboration.
    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("clock_divider_bank: N_CH out of range");
    end
    if (DIV_W < 1 || DIV_W > MAX_DIV_W) begin : g_bad_div_w
        $error("clock_divider_bank: DIV_W out of range");
    end

    logic [N_CH-1:0] w_pend_vld;
    logic [N_CH-1:0] w_wr;
    logic            w_sync;
    logic            w_ready;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync;
`else
    // Without the sync feature, channels only realign through reset.
    assign w_sync = 1'b0;
`endif

    // Ready tracks the addressed channel's pending flag. An index beyond the
    // last channel matches nothing, so the write is accepted and dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if ((cfg_ch == CH_W'(i)) && w_pend_vld[i]) begin
                w_ready = 1'b0;
            end
        end
    end

    assign cfg_ready = w_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Per-channel write strobe decoded from the accepted handshake.
        assign w_wr[g] = cfg_valid && w_ready && (cfg_ch == CH_W'(g));

        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .i_wr       (w_wr[g]),
            .i_div      (cfg_div),
            .i_sync     (w_sync),
            .o_pend_vld (w_pend_vld[g]),
            .o_clk_out  (clk_out[g]),
            .o_tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank with a cycle-level reference model and scoreboard.
// Latency: expected outputs are queued before each edge and compared 1 time unit after it.
// Backpressure: cfg_ready is compared against the model's pending state every cycle.
module tb_clock_divider_bank;

    localparam int N_CH        = 3;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 4;
    localparam int CH_W        = 2;

    logic             clock;
    logic             reset;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: remaining cycles in the current period, counted down.
    int m_div  [N_CH];
    int m_left [N_CH];
    int m_pend [N_CH];
    bit m_pv   [N_CH];

    logic [2*N_CH-1:0] sb_q[$];

    clock_divider_bank #(
        .N_CH        (N_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef CLKDIV_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_div[c]  = DEFAULT_DIV;
            m_left[c] = DEFAULT_DIV;
            m_pend[c] = 0;
            m_pv[c]   = 1'b0;
        end
    endfunction

    function automatic logic exp_ready();
        if (int'(cfg_ch) >= N_CH) return 1'b1;
        return !m_pv[int'(cfg_ch)];
    endfunction

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge(output logic [N_CH-1:0] et, output logic [N_CH-1:0] ec);
        int  d;
        int  l;
        bit  wr;
        et = '0;
        ec = '0;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N_CH; c++) begin
            d = m_div[c];
            l = m_left[c];
            et[c] = (d > 0) && (l == d);
            ec[c] = (d > 0) && (l > d / 2);
            wr = cfg_valid && (int'(cfg_ch) == c) && !m_pv[c];
            if (sync || d == 0 || l == 1) begin
                if (m_pv[c]) begin
                    d       = m_pend[c];
                    m_pv[c] = 1'b0;
                end
                m_div[c]  = d;
                m_left[c] = d;
            end else begin
                m_left[c] = l - 1;
            end
            if (wr) begin
                m_pend[c] = int'(cfg_div);
                m_pv[c]   = 1'b1;
            end
        end
    endtask

    // One clock cycle: check ready, queue the model's prediction, compare after the edge.
    task automatic step();
        logic [N_CH-1:0]   et;
        logic [N_CH-1:0]   ec;
        logic [2*N_CH-1:0] exp;
        #1;
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, exp_ready()});
        model_edge(et, ec);
        sb_q.push_back({et, ec});
        @(posedge clock);
        #1;
        exp = sb_q.pop_front();
        check("tick", {29'b0, tick}, {29'b0, exp[2*N_CH-1:N_CH]});
        check("clk_out", {29'b0, clk_out}, {29'b0, exp[N_CH-1:0]});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(div);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] tv;
        logic [11:0] cv;
        int          n;

        reset     = 1'b1;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        model_reset();
        @(posedge clock);
        #1;
        check("rst_tick", {29'b0, tick}, 32'd0);
        check("rst_clk", {29'b0, clk_out}, 32'd0);
        run(3);

        // Release: default ratio 4 gives ticks in cycles 1,5,9 and 2-high/2-low.
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            tv[i] = tick[0];
            cv[i] = clk_out[0];
        end
        check("rel_tick_pat", {20'b0, tv}, 32'h111);
        check("rel_clk_pat", {20'b0, cv}, 32'h333);

        // Channel 1: ratio 3, then 6 written mid-period.
        cfg_write(1, 3);
        run(10);
        cfg_write(1, 6);
        run(16);

        // Channel 0: back-to-back writes; the second waits for the boundary.
        cfg_write(0, 5);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd7;
        #1;
        check("b2b_ready_low", {31'b0, cfg_ready}, 32'd0);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("b2b_in_bound", {31'b0, (n < 20)}, 32'd1);
        check("b2b_waited", {31'b0, (n > 0)}, 32'd1);
        step();
        cfg_valid = 1'b0;
        run(20);

        // Channel 2: disable, then ratio 5, then ratio 1.
        cfg_write(2, 0);
        run(8);
        check("dis_tick", {31'b0, tick[2]}, 32'd0);
        check("dis_clk", {31'b0, clk_out[2]}, 32'd0);
        cfg_write(2, 5);
        run(12);
        cfg_write(2, 1);
        run(6);
        check("d1_tick", {31'b0, tick[2]}, 32'd1);
        check("d1_clk", {31'b0, clk_out[2]}, 32'd1);

        // Out-of-range channel index: accepted and ignored.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_div   = 16'd9;
        #1;
        check("oor_ready", {31'b0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        run(8);

`ifdef CLKDIV_SYNC_EN
        // Sync with channels at ratios 4 and 6: both tick one cycle later.
        cfg_write(0, 4);
        cfg_write(1, 6);
        run(14);
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        check("sync_tick", {30'b0, tick[1:0]}, 32'd3);
        run(10);
`endif

        // Reset mid-period with a pending write on channel 0.
        cfg_write(0, 9);
        cfg_ch = 2'd0;
        #1;
        check("pend_before_rst", {31'b0, cfg_ready}, 32'd0);
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_tick", {29'b0, tick}, 32'd0);
        check("arst_clk", {29'b0, clk_out}, 32'd0);
        check("arst_ready", {31'b0, cfg_ready}, 32'd1);
        @(posedge clock);
        #1;
        run(2);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            tv[i] = tick[0];
            cv[i] = clk_out[0];
        end
        check("rerel_tick_pat", {20'b0, tv}, 32'h111);
        check("rerel_clk_pat", {20'b0, cv}, 32'h333);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
